// File: rtl/iir_coeff_bank.sv
// iir_coeff_bank: double-buffered biquad coefficient store.
// Host edits land in the shadow bank; the datapath reads the active bank.
// A swap promotes the shadow on a frame boundary, then the new active set is
// copied back into the shadow so further edits start from the live values.
module iir_coeff_bank #(
    parameter int COEFF_W = 24,
    parameter int N_SECT  = 4,
    parameter int ADDR_W  = 5,
    parameter logic [N_SECT*5*COEFF_W-1:0] INIT_TABLE = {
        24'h31375C, 24'h3EB56E, 24'h25EA25, 24'h3DD8F8, 24'h25EA25,
        24'h1CBBC1, 24'h36A26E, 24'h25EA25, 24'h41835C, 24'h25EA25,
        24'h109A47, 24'h33BC62, 24'h25EA25, 24'h470B14, 24'h25EA25,
        24'h0AD744, 24'h32FD14, 24'h25EA25, 24'h4B38E9, 24'h25EA25}
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [COEFF_W-1:0] wr_data,
    output logic               wr_err,
    input  logic               rd_en,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [COEFF_W-1:0] rd_data,
    output logic               rd_valid,
    input  logic               swap_req,
    input  logic               frame_start,
    output logic               swap_pending,
    output logic               swap_done,
    output logic               bank_sel
);

    localparam int N_ENT = N_SECT * 5;
    localparam logic [ADDR_W:0]   N_ENT_W  = (ADDR_W+1)'(N_ENT);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_ENT - 1);

    typedef enum logic [1:0] {IDLE, PENDING, COPY} state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   idx_reg;
    logic                bank_sel_reg;
    logic                wr_ready_reg;
    logic                wr_err_reg;
    logic                swap_pending_reg;
    logic                swap_done_reg;
    logic                rd_valid_reg;
    logic [COEFF_W-1:0]  rd_data_reg;

    logic [COEFF_W-1:0]  bank0 [N_ENT];
    logic [COEFF_W-1:0]  bank1 [N_ENT];

    logic wr_fire;
    logic wr_in_range;
    logic rd_in_range;
    logic copying;

    assign wr_fire     = wr_valid && wr_ready_reg;
    assign wr_in_range = {1'b0, wr_addr} < N_ENT_W;
    assign rd_in_range = {1'b0, rd_addr} < N_ENT_W;
    assign copying     = (state_reg == COPY);

    // Per-entry storage. The shadow bank is the one bank_sel does not point at;
    // it takes either a host write or, during copy-back, the active entry.
    // Host writes and copy-back never coincide because wr_ready is low in COPY.
    for (genvar gi = 0; gi < N_ENT; gi++) begin : gen_ent
        logic [COEFF_W-1:0] e0_reg;
        logic [COEFF_W-1:0] e1_reg;
        logic               hit;

        assign hit = (wr_fire && wr_in_range && (wr_addr == ADDR_W'(gi))) ||
                     (copying && (idx_reg == ADDR_W'(gi)));

        // Shadow entry update from host write or copy-back
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                e0_reg <= INIT_TABLE[gi*COEFF_W +: COEFF_W];
                e1_reg <= INIT_TABLE[gi*COEFF_W +: COEFF_W];
            end else if (hit) begin
                if (bank_sel_reg)
                    e0_reg <= copying ? e1_reg : wr_data;
                else
                    e1_reg <= copying ? e0_reg : wr_data;
            end
        end

        assign bank0[gi] = e0_reg;
        assign bank1[gi] = e1_reg;
    end

    // Swap control: IDLE -> (PENDING) -> COPY -> IDLE, with registered flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            idx_reg          <= '0;
            bank_sel_reg     <= 1'b0;
            wr_ready_reg     <= 1'b1;
            swap_pending_reg <= 1'b0;
            swap_done_reg    <= 1'b0;
        end else begin
            swap_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (swap_req) begin
                        wr_ready_reg <= 1'b0;
                        if (frame_start) begin
                            bank_sel_reg <= ~bank_sel_reg;
                            idx_reg      <= '0;
                            state_reg    <= COPY;
                        end else begin
                            swap_pending_reg <= 1'b1;
                            state_reg        <= PENDING;
                        end
                    end
                end
                PENDING: begin
                    if (frame_start) begin
                        bank_sel_reg     <= ~bank_sel_reg;
                        swap_pending_reg <= 1'b0;
                        idx_reg          <= '0;
                        state_reg        <= COPY;
                    end
                end
                COPY: begin
                    if (idx_reg == LAST_IDX) begin
                        state_reg     <= IDLE;
                        wr_ready_reg  <= 1'b1;
                        swap_done_reg <= 1'b1;
                        idx_reg       <= '0;
                    end else begin
                        idx_reg <= idx_reg + ADDR_W'(1);
                    end
                end
                default: begin
                    state_reg        <= IDLE;
                    wr_ready_reg     <= 1'b1;
                    swap_pending_reg <= 1'b0;
                end
            endcase
        end
    end

    // Flag a dropped write whose address falls outside the table
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wr_err_reg <= 1'b0;
        else
            wr_err_reg <= wr_fire && !wr_in_range;
    end

    // Registered read of the active bank; data holds when no strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_en;
            if (rd_en) begin
                if (!rd_in_range)
                    rd_data_reg <= '0;
                else if (bank_sel_reg)
                    rd_data_reg <= bank1[rd_addr];
                else
                    rd_data_reg <= bank0[rd_addr];
            end
        end
    end

    assign wr_ready     = wr_ready_reg;
    assign wr_err       = wr_err_reg;
    assign rd_data      = rd_data_reg;
    assign rd_valid     = rd_valid_reg;
    assign swap_pending = swap_pending_reg;
    assign swap_done    = swap_done_reg;
    assign bank_sel     = bank_sel_reg;

endmodule

// File: tb/tb_iir_coeff_bank.sv
// Testbench for iir_coeff_bank: reads are scored against a queue of expected
// values taken from a two-bank reference model kept by the bench.
module tb_iir_coeff_bank;

    localparam int COEFF_W = 24;
    localparam int ADDR_W  = 5;
    localparam int N_ENT   = 20;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               wr_valid = 1'b0;
    logic               wr_ready;
    logic [ADDR_W-1:0]  wr_addr = '0;
    logic [COEFF_W-1:0] wr_data = '0;
    logic               wr_err;
    logic               rd_en = 1'b0;
    logic [ADDR_W-1:0]  rd_addr = '0;
    logic [COEFF_W-1:0] rd_data;
    logic               rd_valid;
    logic               swap_req = 1'b0;
    logic               frame_start = 1'b0;
    logic               swap_pending;
    logic               swap_done;
    logic               bank_sel;

    iir_coeff_bank dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_err       (wr_err),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .swap_req     (swap_req),
        .frame_start  (frame_start),
        .swap_pending (swap_pending),
        .swap_done    (swap_done),
        .bank_sel     (bank_sel)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [COEFF_W-1:0] init_tab [N_ENT] = '{
        24'h25EA25, 24'h4B38E9, 24'h25EA25, 24'h32FD14, 24'h0AD744,
        24'h25EA25, 24'h470B14, 24'h25EA25, 24'h33BC62, 24'h109A47,
        24'h25EA25, 24'h41835C, 24'h25EA25, 24'h36A26E, 24'h1CBBC1,
        24'h25EA25, 24'h3DD8F8, 24'h25EA25, 24'h3EB56E, 24'h31375C};

    logic [COEFF_W-1:0] m_act [N_ENT];
    logic [COEFF_W-1:0] m_shd [N_ENT];
    logic [COEFF_W-1:0] exp_q [$];
    logic [COEFF_W-1:0] mon_e;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int e = 0; e < N_ENT; e++) begin
            m_act[e] = init_tab[e];
            m_shd[e] = init_tab[e];
        end
    endtask

    // Read scoreboard: every valid read pops one expected value
    always @(posedge clk) begin
        #1;
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                chk("rd_extra", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                $display("[TB] rd data=0x%06h exp=0x%06h", rd_data, mon_e);
                chk("rd_data", 32'(rd_data), 32'(mon_e));
            end
        end
    end

    task automatic rd(input int a);
        @(negedge clk);
        rd_en   = 1'b1;
        rd_addr = ADDR_W'(a);
        exp_q.push_back((a < N_ENT) ? m_act[a] : 24'h0);
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic wr(input int a, input logic [COEFF_W-1:0] d);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = ADDR_W'(a);
        wr_data  = d;
        if (a < N_ENT) m_shd[a] = d;
        $display("[TB] wr addr=%0d data=0x%06h", a, d);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // Request a swap with frame_start 'gap' cycles later (0 = same cycle),
    // then watch a 40-cycle window. 'poke' re-requests a swap mid-copy.
    task automatic swap(input int gap, input bit poke, output int pend,
                        output int low, output int done, output int flips);
        logic bs_exp;
        logic prev;
        bs_exp = ~bank_sel;
        pend = 0; low = 0; done = 0; flips = 0;
        @(negedge clk);
        swap_req    = 1'b1;
        frame_start = (gap == 0);
        for (int i = 1; i <= gap; i++) begin
            @(negedge clk);
            swap_req = 1'b0;
            if (swap_pending) pend++;
            if (i == gap) frame_start = 1'b1;
        end
        @(negedge clk);
        swap_req    = 1'b0;
        frame_start = 1'b0;
        chk("swap_bank", 32'(bank_sel), 32'(bs_exp));
        prev = bank_sel;
        for (int k = 0; k < 40; k++) begin
            if (!wr_ready) low++;
            if (swap_done) done++;
            if (swap_pending) pend++;
            if (bank_sel != prev) flips++;
            prev = bank_sel;
            swap_req    = (poke && k == 3);
            frame_start = (poke && k == 3);
            @(negedge clk);
        end
        swap_req    = 1'b0;
        frame_start = 1'b0;
        for (int e = 0; e < N_ENT; e++) m_act[e] = m_shd[e];
        $display("[TB] swap gap=%0d bank_sel=%0d pend=%0d low=%0d done=%0d", gap, bank_sel, pend, low, done);
    endtask

    task automatic check_swap(input int gap, input int pend, input int low,
                              input int done, input int flips);
        chk("swap_pending_cycles", 32'(pend), 32'(gap));
        chk("wr_ready_low_cycles", 32'(low), 32'd20);
        chk("swap_done_pulses", 32'(done), 32'd1);
        chk("bank_sel_flips", 32'(flips), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int p, l, d, f;
        model_reset();

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_bank_sel", 32'(bank_sel), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_wr_err", 32'(wr_err), 32'd0);
        chk("rst_pending", 32'(swap_pending), 32'd0);
        chk("rst_done", 32'(swap_done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: initial contents
        rd(0);
        rd(19);
        chk("t1_bank_sel", 32'(bank_sel), 32'd0);
        chk("t1_wr_ready", 32'(wr_ready), 32'd1);

        // 2: shadow write is invisible until a framed swap
        wr(3, 24'h123456);
        rd(3);
        swap(5, 1'b0, p, l, d, f);
        check_swap(5, p, l, d, f);
        chk("t2_bank_sel", 32'(bank_sel), 32'd1);
        rd(3);

        // 3: copy-back preserved earlier edit
        wr(4, 24'h0000FF);
        swap(3, 1'b0, p, l, d, f);
        check_swap(3, p, l, d, f);
        chk("t3_bank_sel", 32'(bank_sel), 32'd0);
        rd(3);
        rd(4);

        // 4: out-of-range write and read
        wr(20, 24'h777777);
        chk("t4_wr_err_pulse", 32'(wr_err), 32'd1);
        @(negedge clk);
        chk("t4_wr_err_clear", 32'(wr_err), 32'd0);
        rd(25);

        // 5: same-cycle swap, ignored re-request during copy
        swap(0, 1'b1, p, l, d, f);
        check_swap(0, p, l, d, f);
        chk("t5_bank_sel", 32'(bank_sel), 32'd1);
        swap(2, 1'b0, p, l, d, f);
        check_swap(2, p, l, d, f);
        for (int e = 0; e < N_ENT; e++) rd(e);

        // 6: reset in the middle of copy-back
        @(negedge clk);
        swap_req = 1'b1;
        frame_start = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        frame_start = 1'b0;
        for (int e = 0; e < N_ENT; e++) m_act[e] = m_shd[e];
        repeat (5) @(negedge clk);
        rd_en = 1'b1;
        rd_addr = ADDR_W'(3);
        exp_q.push_back(m_act[3]);
        @(negedge clk);
        rd_en = 1'b0;
        chk("t6_pre_bank_sel", 32'(bank_sel), 32'd1);
        chk("t6_pre_wr_ready", 32'(wr_ready), 32'd0);
        chk("t6_pre_rd_valid", 32'(rd_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_bank_sel", 32'(bank_sel), 32'd0);
        chk("t6_wr_ready", 32'(wr_ready), 32'd1);
        chk("t6_rd_valid", 32'(rd_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        rd(3);
        swap(1, 1'b0, p, l, d, f);
        check_swap(1, p, l, d, f);
        rd(3);

        repeat (3) @(negedge clk);
        chk("rd_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
